ras_ctrl: RTL and testbench
===========================

Name: ras_ctrl

Overview:
- Front-end producer of return-address-stack (RAS) traffic. Snoops the decode-stage instruction stream and classifies MIPS calls and returns.
- Issues push/pop requests to the 8-entry RAS and serves the return-target prediction to the redirect logic.
- Tracks in-flight predictions in a small FIFO and checks each one against the execute-stage resolved target, reporting mispredicts and statistics.
- Sits between the decode stage, the ras block and the execute stage.

Parameters:
- FIFO_DEPTH, 4, number of in-flight return predictions awaiting execute resolution (power of 2, >=2).
- CNT_W, 32, width of statistics counters.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- flush  in  1  pipeline flush; cancels all pending state
- dec_valid  in  1  decode slot holds an instruction
- dec_ready  out  1  ras_ctrl accepts the instruction; fire = dec_valid & dec_ready
- dec_pc  in  32  PC of the decode instruction
- dec_instr  in  32  instruction word
- ras_top_data  in  33  RAS top entry data; [31:0] target, [32] indirect-call flag
- ras_top_valid  in  1  RAS top entry valid
- push_req  out  1  push to RAS
- pop_req  out  1  pop from RAS
- push_data  out  33  {indirect-call flag, call_pc+8}
- ret_pred_valid  out  1  current decode instruction is a return with a valid prediction
- ret_pred_target  out  32  predicted return target
- ex_ret_valid  in  1  execute resolved the oldest return (in order)
- ex_ret_target  in  32  resolved target
- ret_mispredict  out  1  one-cycle pulse on a mismatch
- ret_cnt  out  CNT_W  returns resolved
- ret_miss_cnt  out  CNT_W  mispredicted returns

Behaviour:
Classification (combinational on dec_instr):
- CALL: JAL (op 000011); BGEZAL/BLTZAL (op 000001, rt 10001/10000; includes BAL); JALR with rd=31.
- RET: JR with rs=31 (op 0, funct 001000).
- CALLRET: JALR with rs=31 and rd=31.
- The indirect-call flag is 1 for JALR, 0 otherwise.
- Conditional calls push regardless of their outcome.

FSM, states IDLE and WAIT_DS:
- IDLE: a fire of CALL/RET/CALLRET latches op_kind, push address (dec_pc+32'd8, wraps mod 2^32) and the flag, then moves to WAIT_DS.
- WAIT_DS: the next fire is the delay slot. In that same cycle the FSM issues push_req, pop_req, or both (CALLRET), then returns to IDLE.
- Requests are combinational from (state, fire), so the instruction after the delay slot already sees the updated top.
- A jump/call/return decoded in WAIT_DS is architecturally unpredictable: it is treated as a plain delay slot and creates no new op.

Prediction:
- ret_pred_valid = dec_valid & (RET|CALLRET) & ras_top_valid & state==IDLE.
- ret_pred_target = ras_top_data[31:0].

Prediction FIFO:
- On fire of RET/CALLRET, enqueue {ras_top_valid, ras_top_data[31:0]}.
- dec_ready = 0 when the FIFO is full and dec_instr is RET/CALLRET; otherwise dec_ready = 1.
- On ex_ret_valid, dequeue. If the entry is invalid or its target differs from ex_ret_target, pulse ret_mispredict the next cycle and increment ret_miss_cnt. Increment ret_cnt on every dequeue.
- Enqueue and dequeue in the same cycle are allowed, including when full.
- ex_ret_valid with an empty FIFO: ignore; no counter change (assertion in bench).

Counters:
- Saturate at all-ones.
- Not cleared by flush; cleared only by reset.

Flush:
- Same cycle: suppress push_req/pop_req and enqueue. Next cycle: state=IDLE, FIFO empty, ret_mispredict=0.
- Flush has priority over ex_ret_valid.

Reset values:
- Outputs: push_req=0, pop_req=0, push_data=0, ret_mispredict=0, ret_cnt=0, ret_miss_cnt=0, dec_ready=1.
- Internal state: state IDLE, FIFO empty.
- Reset mid-WAIT_DS drops the pending op.

Decomposition:
- cpu_defs package holds:
  - ras_op_e {OP_NONE, OP_PUSH, OP_POP, OP_PUSHPOP}
  - opcode/funct/rt localparams (OP_JAL, OP_REGIMM, FN_JR, FN_JALR, RT_BGEZAL, RT_BLTZAL)
  - ras_pred_t {valid, target[31:0]}
- One sub-module, ras_pred_fifo: a parameterised synchronous FIFO with full/empty and a flush clear.

Test Plan:
- JAL at 0xBFC00100 fires, delay slot fires next -> push_req=1 exactly on the DS fire cycle, push_data=0x0_BFC00108; no request on the JAL cycle.
- After that push, JR $31 fires with ras_top=0x0_BFC00108 valid -> ret_pred_valid=1, target 0xBFC00108. Pop on the DS fire. Then ex_ret_valid with 0xBFC00108 -> ret_cnt=1, no mispredict.
- JALR $31,$31 at 0x80000000 -> on the DS fire push_req=pop_req=1, push_data=0x1_80000008; one FIFO entry enqueued.
- Four unresolved returns fill the FIFO, then a fifth JR -> dec_ready=0. The same-cycle ex_ret_valid dequeue restores dec_ready=1 combinationally. A wrong target gives a ret_mispredict pulse and ret_miss_cnt=1.
- Call fired, flush asserted before the DS fires -> no push_req ever issued, FIFO empty, state IDLE; counters unchanged.
- dec_pc=0xFFFFFFFC JAL -> push_data[31:0]=0x00000004 (wrap). Repeat misses with ret_miss_cnt preset near max (CNT_W=4 build) -> saturates at 0xF.

Source files
------------

// File: rtl/cpu_defs.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cpu_defs : shared MIPS decode constants and RAS prediction types           |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package cpu_defs;

  typedef enum logic [1:0] {
    OP_NONE    = 2'd0,
    OP_PUSH    = 2'd1,
    OP_POP     = 2'd2,
    OP_PUSHPOP = 2'd3
  } ras_op_e;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] OP_REGIMM  = 6'b000001;
  localparam logic [5:0] FN_JR      = 6'b001000;
  localparam logic [5:0] FN_JALR    = 6'b001001;
  localparam logic [4:0] RT_BGEZAL  = 5'b10001;
  localparam logic [4:0] RT_BLTZAL  = 5'b10000;
  localparam logic [4:0] REG_RA     = 5'd31;

  typedef struct packed {
    logic        valid;
    logic [31:0] target;
  } ras_pred_t;

  // An invalid prediction always counts as a miss, whatever the target.
  function automatic logic pred_miss(input ras_pred_t p, input logic [31:0] target);
    return !p.valid || (p.target != target);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ras_pred_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ras_pred_fifo : synchronous FIFO of in-flight return predictions           |
// | Revision      : 1.0                                                        |
// +----------------------------------------------------------------------------+
module ras_pred_fifo
  import cpu_defs::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      flush_i,
  input  logic      wr_en_i,
  input  ras_pred_t wr_data_i,
  input  logic      rd_en_i,
  output ras_pred_t rd_data_o,
  output logic      full_o,
  output logic      empty_o
);

  localparam int         AW      = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  ras_pred_t   mem_q [DEPTH];
  logic [AW:0] wr_ptr_q;
  logic [AW:0] rd_ptr_q;
  logic        do_wr;
  logic        do_rd;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_rd     = rd_en_i && !empty_o;
  assign do_wr     = wr_en_i && (!full_o || do_rd);
  assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_rd) rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
  end

endmodule
`default_nettype wire

// File: rtl/ras_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ras_ctrl : classifies decode calls/returns, drives RAS push/pop, checks    |
// |            return predictions against execute                              |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module ras_ctrl
  import cpu_defs::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             dec_valid,
  output logic             dec_ready,
  input  logic [31:0]      dec_pc,
  input  logic [31:0]      dec_instr,
  input  logic [32:0]      ras_top_data,
  input  logic             ras_top_valid,
  output logic             push_req,
  output logic             pop_req,
  output logic [32:0]      push_data,
  output logic             ret_pred_valid,
  output logic [31:0]      ret_pred_target,
  input  logic             ex_ret_valid,
  input  logic [31:0]      ex_ret_target,
  output logic             ret_mispredict,
  output logic [CNT_W-1:0] ret_cnt,
  output logic [CNT_W-1:0] ret_miss_cnt
);

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    WAIT_DS = 1'b1
  } state_e;

  state_e           state_q, state_d;
  ras_op_e          op_q, op_d;
  logic [31:0]      addr_q, addr_d;
  logic             flag_q, flag_d;
  logic             mispredict_q;
  logic [CNT_W-1:0] ret_cnt_q;
  logic [CNT_W-1:0] ret_miss_cnt_q;

  logic [5:0] opc, fn;
  logic [4:0] rs, rt, rd;
  logic       is_jalr, is_call, is_ret, is_callret, dec_is_ret;
  ras_op_e    dec_op;
  logic       fire, enq, deq, fifo_full, fifo_empty;
  ras_pred_t  head;
  logic       unused_bits;

  assign opc = dec_instr[31:26];
  assign rs  = dec_instr[25:21];
  assign rt  = dec_instr[20:16];
  assign rd  = dec_instr[15:11];
  assign fn  = dec_instr[5:0];

  assign is_jalr    = (opc == OP_SPECIAL) && (fn == FN_JALR);
  assign is_call    = (opc == OP_JAL) ||
                      ((opc == OP_REGIMM) && ((rt == RT_BGEZAL) || (rt == RT_BLTZAL))) ||
                      (is_jalr && (rd == REG_RA));
  assign is_ret     = (opc == OP_SPECIAL) && (fn == FN_JR) && (rs == REG_RA);
  assign is_callret = is_jalr && (rs == REG_RA) && (rd == REG_RA);
  assign dec_is_ret = is_ret || is_callret;

  always_comb begin
    dec_op = OP_NONE;
    if (is_callret)   dec_op = OP_PUSHPOP;
    else if (is_call) dec_op = OP_PUSH;
    else if (is_ret)  dec_op = OP_POP;
  end

  assign unused_bits = ^{dec_instr[10:6], ras_top_data[32]};

  // A same-cycle dequeue frees a slot, so it releases the full-FIFO stall.
  assign deq       = ex_ret_valid && !fifo_empty && !flush;
  assign dec_ready = !(fifo_full && dec_is_ret) || deq;
  assign fire      = dec_valid && dec_ready;
  assign enq       = fire && dec_is_ret && !flush;

  ras_pred_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .flush_i  (flush),
    .wr_en_i  (enq),
    .wr_data_i({ras_top_valid, ras_top_data[31:0]}),
    .rd_en_i  (deq),
    .rd_data_o(head),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= OP_NONE;
      addr_q  <= '0;
      flag_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      flag_q  <= flag_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    addr_d   = addr_q;
    flag_d   = flag_q;
    push_req = 1'b0;
    pop_req  = 1'b0;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (fire && (dec_op != OP_NONE)) begin
            op_d    = dec_op;
            addr_d  = dec_pc + 32'd8;
            flag_d  = is_jalr;
            state_d = WAIT_DS;
          end
        end
        WAIT_DS: begin
          // Any fire here is the delay slot; branches in it are ignored.
          if (fire) begin
            push_req = (op_q == OP_PUSH) || (op_q == OP_PUSHPOP);
            pop_req  = (op_q == OP_POP)  || (op_q == OP_PUSHPOP);
            state_d  = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign push_data       = {flag_q, addr_q};
  assign ret_pred_valid  = dec_valid && dec_is_ret && ras_top_valid && (state_q == IDLE);
  assign ret_pred_target = ras_top_data[31:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      mispredict_q   <= 1'b0;
      ret_cnt_q      <= '0;
      ret_miss_cnt_q <= '0;
    end else begin
      mispredict_q <= deq && pred_miss(head, ex_ret_target);
      if (deq) begin
        if (ret_cnt_q != '1) ret_cnt_q <= ret_cnt_q + 1'b1;
        if (pred_miss(head, ex_ret_target) && (ret_miss_cnt_q != '1))
          ret_miss_cnt_q <= ret_miss_cnt_q + 1'b1;
      end
    end
  end

  assign ret_mispredict = mispredict_q;
  assign ret_cnt        = ret_cnt_q;
  assign ret_miss_cnt   = ret_miss_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_ras_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_ras_ctrl : self-checking bench for ras_ctrl (32-bit and 4-bit counters) |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module tb_ras_ctrl;

  localparam logic [31:0] JR_RA = 32'h03E00008;
  localparam logic [31:0] JAL   = 32'h0C000000;
  localparam logic [31:0] NOP   = 32'h00000000;
  localparam int          DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset, flush, dec_valid, ras_top_valid, ex_ret_valid;
  logic [31:0] dec_pc, dec_instr, ex_ret_target;
  logic [32:0] ras_top_data;
  logic        ret_like;

  logic        dec_ready, push_req, pop_req, ret_pred_valid, ret_mispredict;
  logic [32:0] push_data;
  logic [31:0] ret_pred_target, ret_cnt, ret_miss_cnt;

  logic        d4_ready, d4_push, d4_pop, d4_pv, d4_mis;
  logic [32:0] d4_data;
  logic [31:0] d4_tgt;
  logic [3:0]  d4_cnt, d4_miss;

  always #5 clk = ~clk;

  ras_ctrl #(.FIFO_DEPTH(DEPTH), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .flush(flush), .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_pc(dec_pc), .dec_instr(dec_instr), .ras_top_data(ras_top_data),
    .ras_top_valid(ras_top_valid), .push_req(push_req), .pop_req(pop_req),
    .push_data(push_data), .ret_pred_valid(ret_pred_valid), .ret_pred_target(ret_pred_target),
    .ex_ret_valid(ex_ret_valid), .ex_ret_target(ex_ret_target),
    .ret_mispredict(ret_mispredict), .ret_cnt(ret_cnt), .ret_miss_cnt(ret_miss_cnt)
  );

  ras_ctrl #(.FIFO_DEPTH(DEPTH), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .flush(flush), .dec_valid(dec_valid), .dec_ready(d4_ready),
    .dec_pc(dec_pc), .dec_instr(dec_instr), .ras_top_data(ras_top_data),
    .ras_top_valid(ras_top_valid), .push_req(d4_push), .pop_req(d4_pop),
    .push_data(d4_data), .ret_pred_valid(d4_pv), .ret_pred_target(d4_tgt),
    .ex_ret_valid(ex_ret_valid), .ex_ret_target(ex_ret_target),
    .ret_mispredict(d4_mis), .ret_cnt(d4_cnt), .ret_miss_cnt(d4_miss)
  );

  typedef struct packed {
    logic        v;
    logic [31:0] t;
  } pred_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        pv;
    logic        push;
    logic        pop;
    logic [32:0] data;
  } vec_t;

  pred_t       mq[$];
  logic        sb[$];
  logic [31:0] exp_cnt, exp_miss;
  logic [3:0]  exp_cnt4, exp_miss4;
  int          n_chk = 0;
  int          n_fail = 0;
  vec_t        vec [13];

  task automatic chk(input string nm, input logic [32:0] act, input logic [32:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins, input logic rl);
    dec_valid = v;
    dec_pc    = pc;
    dec_instr = ins;
    ret_like  = rl;
  endtask

  task automatic clear_model();
    mq.delete();
    sb.delete();
    exp_cnt = '0; exp_miss = '0; exp_cnt4 = '0; exp_miss4 = '0;
  endtask

  // One clock: check dec_ready, advance the model, then score any resolved return.
  task automatic step();
    logic  exp_ready, deq, enq, miss, m;
    pred_t h;
    deq       = ex_ret_valid && !flush && (mq.size() > 0);
    exp_ready = !((mq.size() == DEPTH) && ret_like) || deq;
    chk("dec_ready", dec_ready, exp_ready);
    enq  = dec_valid && exp_ready && ret_like && !flush;
    miss = 1'b0;
    if (deq) begin
      h    = mq.pop_front();
      miss = !h.v || (h.t != ex_ret_target);
      if (exp_cnt  != '1) exp_cnt++;
      if (exp_cnt4 != '1) exp_cnt4++;
      if (miss && exp_miss  != '1) exp_miss++;
      if (miss && exp_miss4 != '1) exp_miss4++;
    end
    if (flush) mq.delete();
    else if (enq) mq.push_back({ras_top_valid, ras_top_data[31:0]});
    if (ex_ret_valid) sb.push_back(miss);
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      m = sb.pop_front();
      chk("ret_mispredict", ret_mispredict, m);
      chk("ret_cnt", ret_cnt, exp_cnt);
      chk("ret_miss_cnt", ret_miss_cnt, exp_miss);
      chk("ret_cnt4", d4_cnt, exp_cnt4);
      chk("ret_miss_cnt4", d4_miss, exp_miss4);
    end
    @(negedge clk);
  endtask

  task automatic resolve(input logic [31:0] t);
    drive(1'b0, 32'h0, NOP, 1'b0);
    ex_ret_valid  = 1'b1;
    ex_ret_target = t;
    #1;
    step();
    ex_ret_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec[0]  = '{32'hBFC00100, 32'h0C000000, 1'b0, 1'b1, 1'b0, {1'b0, 32'hBFC00108}};
    vec[1]  = '{32'hBFC00200, JR_RA,        1'b1, 1'b0, 1'b1, 33'h0};
    vec[2]  = '{32'h80000000, 32'h03E0F809, 1'b1, 1'b1, 1'b1, {1'b1, 32'h80000008}};
    vec[3]  = '{32'h00001000, 32'h04910010, 1'b0, 1'b1, 1'b0, {1'b0, 32'h00001008}};
    vec[4]  = '{32'h00002000, 32'h04110004, 1'b0, 1'b1, 1'b0, {1'b0, 32'h00002008}};
    vec[5]  = '{32'h00003000, 32'h04B00003, 1'b0, 1'b1, 1'b0, {1'b0, 32'h00003008}};
    vec[6]  = '{32'h00004000, 32'h0040F809, 1'b0, 1'b1, 1'b0, {1'b1, 32'h00004008}};
    vec[7]  = '{32'h00005000, 32'h00400008, 1'b0, 1'b0, 1'b0, 33'h0};
    vec[8]  = '{32'h00006000, 32'h00602809, 1'b0, 1'b0, 1'b0, 33'h0};
    vec[9]  = '{32'h00007000, 32'h00851021, 1'b0, 1'b0, 1'b0, 33'h0};
    vec[10] = '{32'h00008000, 32'h04800005, 1'b0, 1'b0, 1'b0, 33'h0};
    vec[11] = '{32'hFFFFFFFC, 32'h0C000040, 1'b0, 1'b1, 1'b0, {1'b0, 32'h00000004}};
    vec[12] = '{32'h00009000, 32'h03E02809, 1'b0, 1'b0, 1'b0, 33'h0};

    reset = 1'b1; flush = 1'b0; ex_ret_valid = 1'b0; ex_ret_target = '0;
    ras_top_valid = 1'b1; ras_top_data = {1'b0, 32'hBFC00108};
    drive(1'b0, 32'h0, NOP, 1'b0);
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    chk("rst push_req", push_req, 1'b0);
    chk("rst pop_req", pop_req, 1'b0);
    chk("rst push_data", push_data, 33'h0);
    chk("rst ret_mispredict", ret_mispredict, 1'b0);
    chk("rst ret_cnt", ret_cnt, 32'h0);
    chk("rst ret_miss_cnt", ret_miss_cnt, 32'h0);
    chk("rst dec_ready", dec_ready, 1'b1);
    @(negedge clk);
    reset = 1'b0;

    // Classification table: fire the op, then its delay slot, then resolve returns.
    for (int i = 0; i < 13; i++) begin
      drive(1'b1, vec[i].pc, vec[i].instr, vec[i].pop);
      #1;
      chk($sformatf("v%0d ret_pred_valid", i), ret_pred_valid, vec[i].pv);
      if (vec[i].pv) chk($sformatf("v%0d ret_pred_target", i), ret_pred_target, 32'hBFC00108);
      chk($sformatf("v%0d op-cycle push/pop", i), {push_req, pop_req}, 2'b00);
      step();
      drive(1'b1, vec[i].pc + 32'd4, NOP, 1'b0);
      #1;
      chk($sformatf("v%0d ds push_req", i), push_req, vec[i].push);
      chk($sformatf("v%0d ds pop_req", i), pop_req, vec[i].pop);
      if (vec[i].push) chk($sformatf("v%0d push_data", i), push_data, vec[i].data);
      step();
      if (vec[i].pop) resolve(32'hBFC00108);
    end

    // Fill the prediction FIFO with four unresolved returns.
    for (int k = 0; k < DEPTH; k++) begin
      ras_top_data = {1'b0, 32'h10000000 + 32'(k)};
      drive(1'b1, 32'h00010000 + 32'(k * 16), JR_RA, 1'b1);
      #1;
      step();
      drive(1'b1, 32'h00010004 + 32'(k * 16), NOP, 1'b0);
      #1;
      chk("fill pop_req", pop_req, 1'b1);
      step();
    end
    ras_top_data = {1'b0, 32'h10000004};
    drive(1'b1, 32'h00020000, JR_RA, 1'b1);
    #1;
    chk("full stall dec_ready", dec_ready, 1'b0);
    step();
    ex_ret_valid  = 1'b1;
    ex_ret_target = 32'hDEAD0000;
    #1;
    chk("deq releases dec_ready", dec_ready, 1'b1);
    step();
    ex_ret_valid = 1'b0;
    drive(1'b1, 32'h00020004, NOP, 1'b0);
    #1;
    chk("stalled ret pop_req", pop_req, 1'b1);
    step();
    chk("mispredict one pulse", ret_mispredict, 1'b0);
    for (int k = 1; k <= DEPTH; k++) resolve(32'h10000000 + 32'(k));
    resolve(32'h12345678);

    // Flush between a call and its delay slot, also racing an ex resolution.
    ras_top_data = {1'b0, 32'h20000000};
    drive(1'b1, 32'h00003000, JR_RA, 1'b1); #1; step();
    drive(1'b1, 32'h00003004, NOP, 1'b0);   #1; step();
    drive(1'b1, 32'h00004000, JAL, 1'b0);   #1; step();
    drive(1'b1, 32'h00004004, NOP, 1'b0);
    flush = 1'b1; ex_ret_valid = 1'b1; ex_ret_target = 32'h20000000;
    #1;
    chk("flush push_req", push_req, 1'b0);
    step();
    flush = 1'b0; ex_ret_valid = 1'b0;
    drive(1'b1, 32'h00004008, NOP, 1'b0);
    #1;
    chk("post-flush push_req", push_req, 1'b0);
    step();
    resolve(32'h20000000);

    // Repeated misses; first one through an invalid RAS top entry.
    for (int k = 0; k < 17; k++) begin
      ras_top_valid = (k != 0);
      ras_top_data  = {1'b0, 32'h50000000};
      drive(1'b1, 32'h00060000, JR_RA, 1'b1); #1; step();
      drive(1'b1, 32'h00060004, NOP, 1'b0);   #1; step();
      resolve((k == 0) ? 32'h50000000 : 32'h50000004);
    end
    chk("miss cnt4 saturated", d4_miss, 4'hF);
    ras_top_valid = 1'b1;

    // Reset while waiting for a delay slot drops the pending push.
    drive(1'b1, 32'h00007000, JAL, 1'b0); #1; step();
    drive(1'b0, 32'h0, NOP, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    clear_model();
    drive(1'b1, 32'h00007004, NOP, 1'b0);
    #1;
    chk("reset-in-ds push_req", push_req, 1'b0);
    chk("reset ret_cnt", ret_cnt, 32'h0);
    chk("reset ret_miss_cnt", ret_miss_cnt, 32'h0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
